// File: rtl/bpsk_burst_scheduler.sv
// Burst framer for the BPSK transmit chain: preamble chips, spread payload, silent guard.
// Define BPSK_SCHED_DIFF_EN to differentially encode the payload bits.
module bpsk_burst_scheduler #(
    parameter int DIV_W       = 16,
    parameter int LEN_W       = 12,
    parameter int PRE_CHIPS   = 64,
    parameter int CPB         = 31,
    parameter int GUARD_CHIPS = 16
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] chip_div,
    input  logic [LEN_W-1:0] n_bits,
    input  logic             bit_data,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             gold_chip,
    output logic             code_load,
    output logic             chip_en,
    output logic             mod_data,
    output logic             tx_en,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int MAX_PG    = (PRE_CHIPS > GUARD_CHIPS) ? PRE_CHIPS : GUARD_CHIPS;
    localparam int MAX_CHIPS = (MAX_PG > CPB) ? MAX_PG : CPB;
    localparam int CHIP_W    = $clog2(MAX_CHIPS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PREAMBLE, PAYLOAD, GUARD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
    logic [LEN_W-1:0]  nbits_q, nbits_d, bit_q, bit_d;
    logic [CHIP_W-1:0] chip_q, chip_d;
    logic              buf_full_q, buf_full_d, buf_bit_q, buf_bit_d;
    logic              cur_bit_q, cur_bit_d;
    logic              boundary, burst_end, data_in;
    logic              underrun_d, bit_ready_d, code_load_d, chip_en_d, tx_en_d, busy_d, done_d;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        state_d    = state_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        cnt_d      = cnt_q;
        chip_d     = chip_q;
        bit_d      = bit_q;
        buf_full_d = buf_full_q;
        buf_bit_d  = buf_bit_q;
        cur_bit_d  = cur_bit_q;
        underrun_d = underrun;
        boundary   = 1'b0;
        burst_end  = 1'b0;
        data_in    = 1'b0;

        if (bit_valid && bit_ready) begin
            buf_full_d = 1'b1;
            buf_bit_d  = bit_data;
        end

        // chip_en is the registered terminal count of cnt_q, so it doubles as the chip tick.
        if (state_q inside {PREAMBLE, PAYLOAD, GUARD})
            cnt_d = chip_en ? '0 : cnt_q + DIV_W'(1);

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = LOAD;
                    div_d      = chip_div;
                    nbits_d    = n_bits;
                    underrun_d = 1'b0;
                end
            end
            LOAD: begin
                state_d    = PREAMBLE;
                cnt_d      = '0;
                chip_d     = '0;
                bit_d      = '0;
                buf_full_d = 1'b0;
                cur_bit_d  = 1'b0;
            end
            PREAMBLE: begin
                if (chip_en) begin
                    if (chip_q == CHIP_W'(PRE_CHIPS - 1)) begin
                        chip_d = '0;
                        if (nbits_q == '0) begin
                            state_d = GUARD;
                        end else begin
                            state_d  = PAYLOAD;
                            boundary = 1'b1;
                        end
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (chip_en) begin
                    if (chip_q == CHIP_W'(CPB - 1)) begin
                        chip_d = '0;
                        if (bit_q == nbits_q - LEN_W'(1)) begin
                            state_d = GUARD;
                        end else begin
                            bit_d    = bit_q + LEN_W'(1);
                            boundary = 1'b1;
                        end
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                    end
                end
            end
            GUARD: begin
                if (chip_en) begin
                    if (chip_q == CHIP_W'(GUARD_CHIPS - 1)) begin
                        state_d   = IDLE;
                        burst_end = 1'b1;
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Buffer is never refilled on the edge it drains: bit_ready is low while it is full.
        if (boundary) begin
            if (buf_full_q) begin
                data_in    = buf_bit_q;
                buf_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
`ifdef BPSK_SCHED_DIFF_EN
            cur_bit_d = data_in ^ cur_bit_q;
`else
            cur_bit_d = data_in;
`endif
        end

        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            buf_full_d = 1'b0;
            underrun_d = underrun;
            burst_end  = 1'b0;
        end

        code_load_d = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        tx_en_d     = (state_d inside {PREAMBLE, PAYLOAD});
        chip_en_d   = (state_d inside {PREAMBLE, PAYLOAD, GUARD}) && (cnt_d == div_d);
        bit_ready_d = tx_en_d && !buf_full_d;
        done_d      = burst_end;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            nbits_q    <= '0;
            cnt_q      <= '0;
            chip_q     <= '0;
            bit_q      <= '0;
            buf_full_q <= 1'b0;
            buf_bit_q  <= 1'b0;
            cur_bit_q  <= 1'b0;
            underrun   <= 1'b0;
            bit_ready  <= 1'b0;
            code_load  <= 1'b0;
            chip_en    <= 1'b0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every register updates from the same pre-edge values.
            state_q    <= state_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            cnt_q      <= cnt_d;
            chip_q     <= chip_d;
            bit_q      <= bit_d;
            buf_full_q <= buf_full_d;
            buf_bit_q  <= buf_bit_d;
            cur_bit_q  <= cur_bit_d;
            underrun   <= underrun_d;
            bit_ready  <= bit_ready_d;
            code_load  <= code_load_d;
            chip_en    <= chip_en_d;
            tx_en      <= tx_en_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // The chip must follow gold_chip within the same cycle; tx_en gates it to 0 outside the burst.
    assign mod_data = tx_en & (gold_chip ^ cur_bit_q);

endmodule

// File: tb/tb_bpsk_burst_scheduler.sv
// Self-checking bench for bpsk_burst_scheduler: expected payload bits are queued when the
// source hands them over and popped at each bit boundary; timing follows the burst formulas.
module tb_bpsk_burst_scheduler;

    localparam int DIV_W = 16;
    localparam int LEN_W = 12;
    localparam int PRE   = 4;
    localparam int CPB   = 2;
    localparam int GUARD = 2;

    logic             sys_clk   = 1'b0;
    logic             reset_n   = 1'b0;
    logic             start     = 1'b0;
    logic             abort     = 1'b0;
    logic [DIV_W-1:0] chip_div  = '0;
    logic [LEN_W-1:0] n_bits    = '0;
    logic             bit_data  = 1'b0;
    logic             bit_valid = 1'b0;
    logic             gold_chip;
    logic             bit_ready, code_load, chip_en, mod_data, tx_en, busy, done, underrun;

    logic [4:0] lfsr;
    int         n_vec = 0;
    int         n_err = 0;

    bit exp_q[$];
    bit src_bits[8];
    int src_idx, src_n;
    bit valid_en, tb_full, exp_bit, exp_und, prev_enc;

    bpsk_burst_scheduler #(
        .DIV_W(DIV_W), .LEN_W(LEN_W), .PRE_CHIPS(PRE), .CPB(CPB), .GUARD_CHIPS(GUARD)
    ) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .chip_div (chip_div),
        .n_bits   (n_bits),
        .bit_data (bit_data),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .gold_chip(gold_chip),
        .code_load(code_load),
        .chip_en  (chip_en),
        .mod_data (mod_data),
        .tx_en    (tx_en),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Stand-in Gold generator: reseeded by code_load, stepped by chip_en.
    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)       lfsr <= 5'h15;
        else if (code_load) lfsr <= 5'h15;
        else if (chip_en)   lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    end
    assign gold_chip = lfsr[0];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".bit_ready"}, int'(bit_ready), 0);
        check({tag, ".code_load"}, int'(code_load), 0);
        check({tag, ".chip_en"},   int'(chip_en),   0);
        check({tag, ".mod_data"},  int'(mod_data),  0);
        check({tag, ".tx_en"},     int'(tx_en),     0);
        check({tag, ".busy"},      int'(busy),      0);
        check({tag, ".done"},      int'(done),      0);
        check({tag, ".underrun"},  int'(underrun),  0);
    endtask

    // Runs one burst from an IDLE negedge; k counts cycles after the edge that samples start.
    task automatic run_burst(input int div, input int nb, input bit vld,
                             input int abort_at, input bit poke_start);
        int    end_k, tx_end, pay_start, ce_cnt;
        bit    e_tx, e_ce, e_mod, aborted;
        string t;
        end_k     = 2 + (PRE + nb * CPB + GUARD) * (div + 1);
        tx_end    = 2 + (PRE + nb * CPB) * (div + 1);
        pay_start = 2 + PRE * (div + 1);
        chip_div  = DIV_W'(div);
        n_bits    = LEN_W'(nb);
        valid_en  = vld;
        src_idx   = 0;
        src_n     = nb;
        exp_q.delete();
        tb_full   = 1'b0;
        exp_bit   = 1'b0;
        exp_und   = 1'b0;
        prev_enc  = 1'b0;
        ce_cnt    = 0;
        aborted   = 1'b0;
        start     = 1'b1;
        @(posedge sys_clk);
        for (int k = 1; k <= end_k; k++) begin
            @(negedge sys_clk);
            if (k == 1) start = 1'b0;
            if (poke_start) start = (k == 6);
            if (abort_at > 0 && k == abort_at + 1) begin
                t = $sformatf("abort@%0d", k);
                check({t, ".busy"},      int'(busy),      0);
                check({t, ".tx_en"},     int'(tx_en),     0);
                check({t, ".done"},      int'(done),      0);
                check({t, ".bit_ready"}, int'(bit_ready), 0);
                check({t, ".mod_data"},  int'(mod_data),  0);
                check({t, ".underrun"},  int'(underrun),  int'(exp_und));
                abort     = 1'b0;
                bit_valid = 1'b0;
                exp_q.delete();
                tb_full   = 1'b0;
                aborted   = 1'b1;
                break;
            end
            e_tx  = (k >= 2 && k < tx_end);
            e_ce  = (k >= 2 && k < end_k && ((k - 2) % (div + 1)) == div);
            e_mod = 1'b0;
            if (k >= pay_start && k < tx_end) begin
                if (((k - pay_start) % ((div + 1) * CPB)) == 0) begin
                    if (exp_q.size() > 0) begin
                        exp_bit = exp_q.pop_front();
                        tb_full = 1'b0;
                    end else begin
`ifdef BPSK_SCHED_DIFF_EN
                        exp_bit = prev_enc;
`else
                        exp_bit = 1'b0;
`endif
                        exp_und = 1'b1;
                    end
                end
                e_mod = gold_chip ^ exp_bit;
            end else if (e_tx) begin
                e_mod = gold_chip;
            end
            if (chip_en) ce_cnt++;
            t = $sformatf("k%0d", k);
            check({t, ".code_load"}, int'(code_load), int'(k == 1));
            check({t, ".busy"},      int'(busy),      int'(k < end_k));
            check({t, ".done"},      int'(done),      int'(k == end_k));
            check({t, ".tx_en"},     int'(tx_en),     int'(e_tx));
            check({t, ".chip_en"},   int'(chip_en),   int'(e_ce));
            check({t, ".bit_ready"}, int'(bit_ready), int'(e_tx && !tb_full));
            check({t, ".mod_data"},  int'(mod_data),  int'(e_mod));
            check({t, ".underrun"},  int'(underrun),  int'(exp_und));
            if (abort_at > 0 && k == abort_at) abort = 1'b1;
            // Source side: a handshake seen here completes on the next rising edge.
            if (valid_en && src_idx < src_n) begin
                bit_valid = 1'b1;
                bit_data  = src_bits[src_idx];
            end else begin
                bit_valid = 1'b0;
            end
            if (bit_valid && bit_ready) begin
`ifdef BPSK_SCHED_DIFF_EN
                prev_enc = bit_data ^ prev_enc;
                exp_q.push_back(prev_enc);
`else
                exp_q.push_back(bit_data);
`endif
                tb_full = 1'b1;
                src_idx++;
            end
        end
        if (!aborted) check("chip_en_count", ce_cnt, PRE + nb * CPB + GUARD);
        bit_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge sys_clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge sys_clk);

        src_bits = '{1, 0, 1, 0, 0, 0, 0, 0};
        run_burst(3, 3, 1'b1, 0, 1'b1);
        run_burst(0, 0, 1'b0, 0, 1'b0);
        run_burst(3, 3, 1'b0, 0, 1'b0);
        check("underrun_sticky_idle", int'(underrun), 1);
        run_burst(3, 3, 1'b1, 20, 1'b0);
        run_burst(3, 3, 1'b1, 0, 1'b0);
        src_bits = '{0, 1, 0, 0, 0, 0, 0, 0};
        run_burst(1, 2, 1'b1, 0, 1'b0);
`ifdef BPSK_SCHED_DIFF_EN
        src_bits = '{1, 1, 0, 0, 0, 0, 0, 0};
        run_burst(3, 3, 1'b1, 0, 1'b0);
`endif

        start = 1'b1;
        abort = 1'b1;
        @(negedge sys_clk);
        check("start_abort_idle.code_load", int'(code_load), 0);
        check("start_abort_idle.busy",      int'(busy),      0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge sys_clk);

        chip_div = DIV_W'(3);
        n_bits   = LEN_W'(3);
        start    = 1'b1;
        @(posedge sys_clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge sys_clk);
            start = 1'b0;
        end
        check("pre_reset.busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);
        check("post_reset.busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bpsk_burst_scheduler.md
# bpsk_burst_scheduler

Sequences the BPSK transmit chain as framed bursts: reloads the Gold-code generator, paces its chip clock from `sys_clk`, and spreads payload bits over Gold chips for the modulator. Each burst is a preamble of bare code chips, a payload of spread data bits, and a silent guard interval. The block sits between the payload source and the `gold_code_generator`/`bpsk_modulator` pair, replacing the free-running `code_clk` with a `sys_clk`-domain chip enable.

## Interface
- `DIV_W`, 16, width of the chip divider.
- `LEN_W`, 12, width of the payload bit count.
- `PRE_CHIPS`, 64, preamble length in chips (≥1).
- `CPB`, 31, chips per payload bit (≥1).
- `GUARD_CHIPS`, 16, guard length in chips (≥1).

Ports:
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: burst request, level-sampled; honoured only in IDLE.
- `abort` in 1: terminate the burst immediately.
- `chip_div` in DIV_W: sys_clk cycles per chip minus 1; latched on accepted `start`.
- `n_bits` in LEN_W: payload bits; latched on accepted `start`; 0 skips PAYLOAD.
- `bit_data` in 1: payload bit.
- `bit_valid` in 1: `bit_data` valid.
- `bit_ready` out 1: one-entry bit buffer empty and accepting.
- `gold_chip` in 1: current generator output chip.
- `code_load` out 1: one-cycle pulse that reloads the generator seed.
- `chip_en` out 1: one-cycle strobe that advances the generator by one chip.
- `mod_data` out 1: chip to the modulator.
- `tx_en` out 1: modulator enable.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse on normal burst completion.
- `underrun` out 1: sticky flag, cleared on accepted `start`.

## Operation
- States: IDLE → LOAD → PREAMBLE → PAYLOAD → GUARD → IDLE.
- IDLE: `start`=1 latches `chip_div`/`n_bits`, clears `underrun`, goes to LOAD.
- LOAD: one cycle, `code_load`=1; the chip counter and bit buffer are cleared.
- Chip counter counts 0..chip_div; at terminal count `chip_en`=1 for one cycle and the chip index increments. `chip_div`=0 gives a chip every cycle.
- PREAMBLE: `mod_data`=`gold_chip` for PRE_CHIPS chips.
- PAYLOAD: n_bits×CPB chips, `mod_data`=`gold_chip` XOR current bit.
- Bit buffer behaviour:
  - `bit_ready`=1 while the buffer is empty in PREAMBLE or PAYLOAD.
  - A transfer occurs when `bit_valid`&`bit_ready`.
  - At each bit boundary (the first payload chip and every CPB chips after), the buffered bit becomes the current bit.
  - If the buffer is empty at a bit boundary, the current bit is 0 and `underrun` is set.
- GUARD: `mod_data`=0 and `tx_en`=0 for GUARD_CHIPS chips; then IDLE with `done`=1 for one cycle.
- `tx_en`=1 exactly in PREAMBLE and PAYLOAD.
- `abort` in any non-IDLE state: next cycle IDLE, `done`=0, buffer flushed, `tx_en`=0, `underrun` held. `abort` with `start` in IDLE: abort wins, start ignored.
- `start` while `busy`: ignored.

## Timing
- All outputs registered. Reset values: `bit_ready`, `code_load`, `chip_en`, `mod_data`, `tx_en`, `busy`, `done`, `underrun` = 0.
- `start` sampled at edge T: `code_load`=1 and `busy`=1 in cycle T+1; PREAMBLE and `tx_en`=1 from T+2.
- First `chip_en` at T+2+chip_div. Each state lasts (chips)×(chip_div+1) cycles.
- `done` pulses in the cycle IDLE is re-entered, i.e. T+2+(PRE_CHIPS+n_bits×CPB+GUARD_CHIPS)×(chip_div+1).
- The next `start` is accepted in the same cycle `done` is high.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous), and the latched config is cleared.

## Configuration
- `BPSK_SCHED_DIFF_EN` defined: payload is differentially encoded. The current bit equals the buffered bit XOR the previous encoded bit; the previous encoded bit resets to 0 in LOAD. An underrun inserts data 0, so the previous encoded bit repeats.
- Undefined: the current bit equals the buffered bit directly.

## Test plan
- Basic burst, PRE_CHIPS=4, CPB=2, GUARD_CHIPS=2, chip_div=3, n_bits=3, bits 1,0,1 always valid, `start` at T:
  - 12 `chip_en` pulses.
  - `tx_en` high for cycles T+2..T+41.
  - Payload `mod_data` = ~chip, chip, ~chip per bit pair.
  - `done` at T+50; `underrun`=0.
- n_bits=0, chip_div=0, same params: PREAMBLE then GUARD only; `done` at T+8; `bit_ready` high only during PREAMBLE.
- Basic-burst setup with `bit_valid` held low: `underrun`=1 from the first payload chip; `mod_data`=`gold_chip` throughout payload; `underrun` cleared by the next `start`.
- `abort` at cycle T+20 of the basic burst: `busy`=0 and `tx_en`=0 at T+21, no `done`; a new `start` at T+21 gives `code_load` at T+22.
- `start` during busy, and `start`+`abort` together in IDLE: both ignored, no `code_load`. Reset asserted at T+10: all outputs 0 within the same cycle.
- With `BPSK_SCHED_DIFF_EN`, bits 1,1,0 produce encoded bits 1,0,0 on the payload chips.
